// File: rtl/csa_accum_seq.sv
// ---------------------------------------------------------------------------
// csa_accum_seq
//
// Sequencer for a multi-operand carry-save accumulator. Operands arrive over a
// valid/ready stream and are folded into a redundant sum/carry pair (S, C) by
// a row of full adders. The operand flagged with in_last ends the group. The
// pair is then resolved by one shared 4-bit ripple slice, one nibble per
// cycle, and the binary total is offered downstream.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds valid and data stable
// until that edge. Ready never depends on valid in the same cycle.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_data operand, in_last ends group
//   out_valid/out_ready result handshake
//   out_sum             group total mod 2^ACC_W
//   out_ovf             group total did not fit in ACC_W bits
//   out_count           (only with CSA_OP_COUNT_EN) operands in the group,
//                       saturating at 255
//   dbg_state           current FSM state (0 ACCUM, 1 RESOLVE, 2 OUTPUT)
//
// Optional feature macro: CSA_OP_COUNT_EN
// ---------------------------------------------------------------------------
module csa_accum_seq #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
`ifdef CSA_OP_COUNT_EN
    output logic [7:0]       out_count,
`endif
    output logic [1:0]       dbg_state
);

    localparam int NIBS  = ACC_W / 4;
    localparam int NIB_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [ACC_W-1:0]   r_s;
    logic [ACC_W-1:0]   r_c;
    logic [ACC_W-1:0]   r_res;
    logic               r_ovf;
    logic               r_rc;
    logic [NIB_W-1:0]   r_nib;

    logic [ACC_W-1:0]   w_x;
    logic [ACC_W-1:0]   w_maj;
    logic               w_accept;
    logic               w_out_hs;
    logic               w_last_nib;
    logic [4:0]         w_nib_sum;

    assign w_x        = ACC_W'(in_data);
    assign w_maj      = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
    assign w_accept   = in_valid && (r_state == ST_ACCUM);
    assign w_out_hs   = out_ready && (r_state == ST_OUTPUT);
    assign w_last_nib = (r_nib == NIB_W'(NIBS - 1));

    // S and C shift right by a nibble each RESOLVE cycle, so the ripple slice
    // always reads the low nibble; the result nibble enters r_res at the top.
    assign w_nib_sum = {1'b0, r_s[3:0]} + {1'b0, r_c[3:0]} + {4'b0, r_rc};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && in_last) w_next = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (w_last_nib) w_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_ready) w_next = ST_ACCUM;
            end
            default: w_next = ST_ACCUM;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        in_ready  = (r_state == ST_ACCUM);
        out_valid = (r_state == ST_OUTPUT);
        out_sum   = out_valid ? r_res : '0;
        out_ovf   = out_valid && r_ovf;
        dbg_state = r_state;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s   <= '0;
            r_c   <= '0;
            r_res <= '0;
            r_ovf <= 1'b0;
            r_rc  <= 1'b0;
            r_nib <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_s <= r_s ^ r_c ^ w_x;
                        // Carry word is the majority shifted up one place; its
                        // MSB falls off the top and is a lost 2^ACC_W.
                        r_c <= {w_maj[ACC_W-2:0], 1'b0};
                        r_ovf <= r_ovf | w_maj[ACC_W-1];
                        if (in_last) begin
                            r_nib <= '0;
                            r_rc  <= 1'b0;
                        end
                    end
                end
                ST_RESOLVE: begin
                    r_s   <= r_s >> 4;
                    r_c   <= r_c >> 4;
                    r_res <= (r_res >> 4) | (ACC_W'(w_nib_sum[3:0]) << (ACC_W - 4));
                    r_rc  <= w_nib_sum[4];
                    r_nib <= r_nib + NIB_W'(1);
                    if (w_last_nib) r_ovf <= r_ovf | w_nib_sum[4];
                end
                ST_OUTPUT: begin
                    if (w_out_hs) begin
                        r_s   <= '0;
                        r_c   <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: begin
                    r_s   <= '0;
                    r_c   <= '0;
                    r_ovf <= 1'b0;
                end
            endcase
        end
    end

`ifdef CSA_OP_COUNT_EN
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_out_hs) begin
            r_cnt <= 8'd0;
        end else if (w_accept && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign out_count = r_cnt;
`endif

endmodule

// File: tb/tb_csa_accum_seq.sv
// Bench for csa_accum_seq (WIDTH=8, ACC_W=12). All tasks start and end just
// after a falling clk edge; inputs are driven there and outputs sampled there.
// The reference model keeps the plain integer total of each group.
module tb_csa_accum_seq;

    localparam int WIDTH = 8;
    localparam int ACC_W = 12;
    localparam int NIBS  = ACC_W / 4;
    localparam int EXP_W = 8 + 1 + ACC_W;   // {count, ovf, sum}

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
`ifdef CSA_OP_COUNT_EN
    logic [7:0]       out_count;
`endif
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    longint grp_total = 0;
    int     grp_n     = 0;
    logic [EXP_W-1:0] exp_q[$];

    csa_accum_seq #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
`ifdef CSA_OP_COUNT_EN
        .out_count (out_count),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one operand ----------------
    task automatic send_op(input logic [WIDTH-1:0] d, input logic last);
        int     wait_n;
        longint tot;
        int     cnt;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        wait_n   = 0;
        while (!in_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        chk("in_ready_wait", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        grp_total += longint'(d);
        grp_n++;
        if (last) begin
            tot = grp_total % (longint'(1) << ACC_W);
            cnt = (grp_n > 255) ? 255 : grp_n;
            exp_q.push_back({8'(cnt), (grp_total >= (longint'(1) << ACC_W)), ACC_W'(tot)});
            grp_total = 0;
            grp_n     = 0;
        end
    endtask

    // ---------------- driver + scoreboard: one result ----------------
    // Called right after the accept of the last operand. hold_v/hold_d model a
    // producer that already presents its next operand while in_ready is low.
    task automatic get_result(input int stall, input logic hold_v, input logic [WIDTH-1:0] hold_d);
        logic [EXP_W-1:0] e;
        logic [ACC_W-1:0] e_sum;
        logic             e_ovf;
        logic [7:0]       e_cnt;
        int               lat;
        in_valid  = hold_v;
        in_data   = hold_d;
        in_last   = 1'b0;
        out_ready = 1'b0;
        e = exp_q.pop_front();
        {e_cnt, e_ovf, e_sum} = e;
        // Cycle t+1 is the first one after the accepting edge.
        lat = 1;
        while (!out_valid && lat < 20) begin
            chk("in_ready_busy", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, NIBS + 1);
        repeat (stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_sum", out_sum, e_sum);
            chk("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk("out_sum", out_sum, e_sum);
        chk("out_ovf", out_ovf, e_ovf);
`ifdef CSA_OP_COUNT_EN
        chk("out_count", out_count, e_cnt);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset condition
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_state", dbg_state, 0);
`ifdef CSA_OP_COUNT_EN
        chk("rst_count", out_count, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // 1: 4 + 5
        send_op(8'd4, 1'b0);
        send_op(8'd5, 1'b1);
        get_result(0, 1'b0, '0);

        // out_ready without out_valid does nothing
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_in_ready", in_ready, 1);
        end
        out_ready = 1'b0;

        // 2: single operand group
        send_op(8'd200, 1'b1);
        get_result(0, 1'b0, '0);

        // 3: 255 x16 fits, 255 x17 wraps
        repeat (15) send_op(8'd255, 1'b0);
        send_op(8'd255, 1'b1);
        get_result(1, 1'b0, '0);
        repeat (16) send_op(8'd255, 1'b0);
        send_op(8'd255, 1'b1);
        get_result(0, 1'b0, '0);

        // 4: long stall, producer holding its next operand meanwhile
        send_op(8'd9, 1'b0);
        send_op(8'd5, 1'b1);
        get_result(10, 1'b1, 8'd2);
        send_op(8'd2, 1'b0);
        send_op(8'd4, 1'b1);
        get_result(0, 1'b0, '0);

        // 5: reset in RESOLVE discards the group
        send_op(8'd100, 1'b0);
        send_op(8'd100, 1'b1);
        void'(exp_q.pop_back());
        in_valid = 1'b0;
        chk("pre_rst_state", dbg_state, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_state", dbg_state, 0);
        chk("post_rst_in_ready", in_ready, 1);
        repeat (6) begin
            chk("post_rst_no_valid", out_valid, 0);
            @(negedge clk);
        end
        send_op(8'd1, 1'b0);
        send_op(8'd2, 1'b1);
        get_result(0, 1'b0, '0);

`ifdef CSA_OP_COUNT_EN
        // 6: operand counting, then saturation
        repeat (2) send_op(8'd3, 1'b0);
        send_op(8'd3, 1'b1);
        get_result(0, 1'b0, '0);
        send_op(8'd7, 1'b1);
        get_result(0, 1'b0, '0);
        for (int i = 0; i < 259; i++) send_op(WIDTH'($urandom_range(0, 255)), 1'b0);
        send_op(WIDTH'($urandom_range(0, 255)), 1'b1);
        get_result(0, 1'b0, '0);
`endif

        // Random groups
        for (int g = 0; g < 10; g++) begin
            int len;
            len = $urandom_range(1, 24);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
                send_op(WIDTH'($urandom_range(0, 255)), (k == len - 1));
            end
            get_result($urandom_range(0, 3), 1'b0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
